sort_pru: RTL and testbench
===========================

SORT_PRU -- requirements
Module: sort_pru

Interface
REQ-001 Parameter DATA_W, default 4: key width; count-memory depth is 2^DATA_W.
REQ-002 Parameter CNT_W, default 8: width of each count-memory entry.
REQ-003 Port clk, input, 1: single clock, rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port ctrl2pru_start_vld_i, input, 1: one-cycle pulse requesting read-out of the selected bank.
REQ-006 Port ctrl_rd_sel_i, input, 1: ping-pong bank to read; sampled with start.
REQ-007 Port pru2ctrl_rd_done_vld_o, output, 1: one-cycle pulse when bank read-out is complete.
REQ-008 Port pru2mem_rd_en_o, output, 1: count-memory read strobe.
REQ-009 Port pru2mem_sel_o, output, 1: bank select for read and clear.
REQ-010 Port pru2mem_addr_o, output, DATA_W: read/clear address.
REQ-011 Port mem2pru_rd_data_i, input, CNT_W: count for the address; valid the cycle after rd_en.
REQ-012 Port pru2mem_clr_en_o, output, 1: write-zero strobe at pru2mem_addr_o.
REQ-013 Port pru_out_vld_o, output, 1: sorted key valid.
REQ-014 Port pru_out_data_o, output, DATA_W: sorted key.
REQ-015 Port pru_out_rdy_i, input, 1: downstream ready; transfer occurs when vld and rdy are both high.

Function
REQ-016 FSM states: IDLE, RD, WAIT, EMIT, NEXT, DONE.
REQ-017 IDLE: on start, latch ctrl_rd_sel_i into sel register, clear addr to 0, go to RD next cycle.
REQ-018 Start while not in IDLE is ignored; no queuing.
REQ-019 RD, 1 cycle: rd_en=1, sel and addr driven from registers; go to WAIT.
REQ-020 WAIT, 1 cycle: capture mem2pru_rd_data_i into remaining-count register. Zero -> NEXT; nonzero -> EMIT.
REQ-021 EMIT: out_vld=1, out_data=addr; each transfer decrements remaining count. The transfer at count 1 goes to NEXT.
REQ-022 EMIT holds vld and data stable while rdy is low; no combinational path from rdy to vld.
REQ-023 NEXT, 1 cycle: addr = 2^DATA_W-1 -> DONE; otherwise addr+1 -> RD.
REQ-024 DONE, 1 cycle: rd_done_vld=1; go to IDLE. addr does not wrap past the last entry.
REQ-025 Keys are emitted in ascending order; total transfers equal the sum of the bank's counts.
REQ-026 Empty bank (all counts zero) completes with no transfers, 3*2^DATA_W+1 cycles from start to the done pulse inclusive.
REQ-027 rd_en, clr_en, out_vld and rd_done are never asserted in IDLE.

Reset
REQ-028 rst_n low asynchronously forces IDLE, including mid-operation.
REQ-029 Reset clears sel, addr and remaining count to 0.
REQ-030 Reset drives every output to 0.
REQ-031 No done pulse is generated for an operation aborted by reset.

Configuration
REQ-032 Macro SORT_PRU_CLR_EN defined: clr_en=1 during WAIT, zeroing the entry just read so the bank is reusable without a separate clear pass.
REQ-033 Macro SORT_PRU_CLR_EN undefined: clr_en is tied to 0; all other behaviour is identical.

Verification (DATA_W=2, CNT_W=4)
REQ-034 Bank0 counts {2,0,1,3}, rdy=1, start with sel=0 -> stream 0,0,2,3,3,3; one done pulse; sel_o=0 throughout.
REQ-035 Bank1 all zero, start with sel=1 -> no out_vld; done pulse 13 cycles after start.
REQ-036 Bank0 counts {0,5,0,0}, rdy toggling 1/0 -> five transfers of key 1, data stable while stalled, then done.
REQ-037 Start re-pulsed during EMIT -> ignored; exactly one done pulse.
REQ-038 rst_n asserted mid-EMIT -> all outputs 0 immediately; next start restarts from addr 0.
REQ-039 With SORT_PRU_CLR_EN: after the REQ-034 run, bank0 reads all zero; without it, bank0 is unchanged {2,0,1,3}.

Source files
------------

// File: rtl/sort_pru.sv
// -----------------------------------------------------------------------------
// sort_pru -- counting-sort read-out unit.
//
// Walks one ping-pong bank of a count memory from address 0 to 2^DATA_W-1.
// Each address holds how many times that key was seen. The unit emits the key
// that many times on a valid/ready stream, which yields the keys in ascending
// order. It pulses done once the last entry has been handled.
//
// Configuration macro: SORT_PRU_CLR_EN
//   When defined, each entry is zeroed (clr_en) in the cycle its count is
//   captured. The bank is then ready for reuse without a separate clear pass.
//   When undefined, clr_en is tied low.
//
// Ports
//   clk                     in   clock, rising edge
//   rst_n                   in   asynchronous active-low reset
//   ctrl2pru_start_vld_i    in   start pulse; ignored unless idle
//   ctrl_rd_sel_i           in   bank to read, sampled with start
//   pru2ctrl_rd_done_vld_o  out  one-cycle pulse when read-out completes
//   pru2mem_rd_en_o         out  count-memory read strobe
//   pru2mem_sel_o           out  bank select for read and clear
//   pru2mem_addr_o          out  read/clear address
//   mem2pru_rd_data_i       in   count, valid the cycle after rd_en
//   pru2mem_clr_en_o        out  write-zero strobe at pru2mem_addr_o
//   pru_out_vld_o           out  sorted key valid
//   pru_out_data_o          out  sorted key
//   pru_out_rdy_i           in   downstream ready
// -----------------------------------------------------------------------------
module sort_pru #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ctrl2pru_start_vld_i,
    input  logic              ctrl_rd_sel_i,
    output logic              pru2ctrl_rd_done_vld_o,
    output logic              pru2mem_rd_en_o,
    output logic              pru2mem_sel_o,
    output logic [DATA_W-1:0] pru2mem_addr_o,
    input  logic [CNT_W-1:0]  mem2pru_rd_data_i,
    output logic              pru2mem_clr_en_o,
    output logic              pru_out_vld_o,
    output logic [DATA_W-1:0] pru_out_data_o,
    input  logic              pru_out_rdy_i
);

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWait,
        StEmit,
        StNext,
        StDone
    } state_e;

    localparam logic [DATA_W-1:0] LastAddr = '1;
    localparam logic [DATA_W-1:0] AddrOne  = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CntOne   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e            r_state;
    state_e            w_state_d;
    logic              r_sel;
    logic              w_sel_d;
    logic [DATA_W-1:0] r_addr;
    logic [DATA_W-1:0] w_addr_d;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_sel   <= 1'b0;
            r_addr  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_sel   <= w_sel_d;
            r_addr  <= w_addr_d;
            r_cnt   <= w_cnt_d;
        end
    end

    always_comb begin
        w_state_d              = r_state;
        w_sel_d                = r_sel;
        w_addr_d               = r_addr;
        w_cnt_d                = r_cnt;
        pru2ctrl_rd_done_vld_o = 1'b0;
        pru2mem_rd_en_o        = 1'b0;
        pru2mem_clr_en_o       = 1'b0;
        pru_out_vld_o          = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (ctrl2pru_start_vld_i) begin
                    w_sel_d   = ctrl_rd_sel_i;
                    w_addr_d  = '0;
                    w_state_d = StRd;
                end
            end
            StRd: begin
                pru2mem_rd_en_o = 1'b1;
                w_state_d       = StWait;
            end
            StWait: begin
`ifdef SORT_PRU_CLR_EN
                // Zero the entry while its count is being captured.
                pru2mem_clr_en_o = 1'b1;
`endif
                w_cnt_d   = mem2pru_rd_data_i;
                w_state_d = (mem2pru_rd_data_i == '0) ? StNext : StEmit;
            end
            StEmit: begin
                // vld depends only on state, so rdy never reaches it combinationally.
                pru_out_vld_o = 1'b1;
                if (pru_out_rdy_i) begin
                    w_cnt_d = r_cnt - CntOne;
                    if (r_cnt == CntOne) begin
                        w_state_d = StNext;
                    end
                end
            end
            StNext: begin
                if (r_addr == LastAddr) begin
                    w_state_d = StDone;
                end else begin
                    w_addr_d  = r_addr + AddrOne;
                    w_state_d = StRd;
                end
            end
            StDone: begin
                pru2ctrl_rd_done_vld_o = 1'b1;
                w_state_d              = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // Registers reset to zero, so these outputs are zero while in reset.
    assign pru2mem_sel_o  = r_sel;
    assign pru2mem_addr_o = r_addr;
    assign pru_out_data_o = r_addr;

endmodule

// File: tb/tb_sort_pru.sv
// -----------------------------------------------------------------------------
// tb_sort_pru -- self-checking bench for sort_pru (DATA_W=2, CNT_W=4).
// Owns a two-bank count memory. A reference model expands the bank contents
// into the expected ascending key stream and done latency.
// -----------------------------------------------------------------------------
module tb_sort_pru;

    localparam int unsigned DW = 2;
    localparam int unsigned CW = 4;
    localparam int unsigned N  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          sel_i = 1'b0;
    logic          done;
    logic          rd_en;
    logic          sel_o;
    logic [DW-1:0] addr;
    logic [CW-1:0] rd_data = '0;
    logic          clr_en;
    logic          out_vld;
    logic [DW-1:0] out_data;
    logic          out_rdy = 1'b0;

    sort_pru #(
        .DATA_W(DW),
        .CNT_W (CW)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .ctrl2pru_start_vld_i  (start),
        .ctrl_rd_sel_i         (sel_i),
        .pru2ctrl_rd_done_vld_o(done),
        .pru2mem_rd_en_o       (rd_en),
        .pru2mem_sel_o         (sel_o),
        .pru2mem_addr_o        (addr),
        .mem2pru_rd_data_i     (rd_data),
        .pru2mem_clr_en_o      (clr_en),
        .pru_out_vld_o         (out_vld),
        .pru_out_data_o        (out_data),
        .pru_out_rdy_i         (out_rdy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Count memory and the shadow copy the model reads.
    logic [CW-1:0] mem     [0:1][0:N-1];
    int            ref_cnt [0:1][0:N-1];

    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[sel_o][addr];
        if (clr_en) mem[sel_o][addr] = '0;
    end

    // 0: always ready, 1: toggle, 2: random, 3: never ready
    int rdy_mode = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: out_rdy = 1'b1;
                1: out_rdy = ~out_rdy;
                2: out_rdy = 1'($urandom_range(0, 1));
                default: out_rdy = 1'b0;
            endcase
        end
    end

    // Observers, sampled on the falling edge.
    logic [DW-1:0] got_q[$];
    logic [DW-1:0] exp_q[$];
    int            done_cnt  = 0;
    int            done_cyc  = 0;
    int            stall_err = 0;
    int            sel_err   = 0;
    logic          exp_sel   = 1'b0;
    logic          prev_vld  = 1'b0;
    logic          prev_rdy  = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_vld = 1'b0;
        end else begin
            if (out_vld && out_rdy) got_q.push_back(out_data);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (prev_vld && !prev_rdy && (!out_vld || out_data != prev_data)) stall_err++;
            if ((rd_en || clr_en) && sel_o != exp_sel) sel_err++;
            prev_vld  = out_vld;
            prev_rdy  = out_rdy;
            prev_data = out_data;
        end
    end

    task automatic load_bank(input int b, input int c0, input int c1, input int c2,
                             input int c3);
        ref_cnt[b][0] = c0;
        ref_cnt[b][1] = c1;
        ref_cnt[b][2] = c2;
        ref_cnt[b][3] = c3;
        for (int k = 0; k < N; k++) mem[b][k] = CW'(ref_cnt[b][k]);
    endtask

    // Model: every key repeated by its count, keys ascending.
    task automatic build_exp(input int b, output int sum);
        exp_q.delete();
        sum = 0;
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < ref_cnt[b][k]; j++) exp_q.push_back(DW'(k));
            sum += ref_cnt[b][k];
        end
    endtask

    // Start pulse, then wait (bounded) for done; lat = cycles start->done.
    task automatic run_op(input logic s, input int bound, output int lat, output bit ok);
        int d0;
        int sc;
        d0 = done_cnt;
        got_q.delete();
        exp_sel = s;
        @(posedge clk);
        #1;
        sel_i = s;
        start = 1'b1;
        sc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        sel_i = 1'b0;
        for (int i = 0; i < bound && done_cnt == d0; i++) @(posedge clk);
        ok = (done_cnt != d0);
        lat = done_cyc - sc;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({done, rd_en, sel_o, addr, clr_en, out_vld, out_data} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got %b required 0",
                     {done, rd_en, sel_o, addr, clr_en, out_vld, out_data});
        end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        n_vec++;
        if (done_cnt !== 0 || got_q.size() !== 0) begin
            n_err++;
            $display("FAIL reset_idle done=%0d xfers=%0d required 0/0", done_cnt, got_q.size());
        end
    endtask

    task automatic test_sort_basic();
        int lat, sum, d0;
        bit ok;
        load_bank(0, 2, 0, 1, 3);
        load_bank(1, 1, 1, 1, 1);
        build_exp(0, sum);
        rdy_mode = 0;
        sel_err = 0;
        d0 = done_cnt;
        run_op(1'b0, 200, lat, ok);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL basic_done_timeout got none required pulse");
        end
        n_vec++;
        if (done_cnt !== d0 + 1) begin
            n_err++;
            $display("FAIL basic_done_count got %0d required 1", done_cnt - d0);
        end
        n_vec++;
        if (got_q.size() !== exp_q.size()) begin
            n_err++;
            $display("FAIL basic_len got %0d required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL basic_key[%0d] got %0d required %0d", i, got_q[i], exp_q[i]);
            end
        end
        n_vec++;
        if (lat !== 3 * N + 1 + sum) begin
            n_err++;
            $display("FAIL basic_latency got %0d required %0d", lat, 3 * N + 1 + sum);
        end
        n_vec++;
        if (sel_err !== 0) begin
            n_err++;
            $display("FAIL basic_sel got %0d wrong-bank strobes required 0", sel_err);
        end
    endtask

    // Runs right after test_sort_basic: bank0 cleared only with the macro.
    task automatic test_clear();
        int want;
        for (int k = 0; k < N; k++) begin
`ifdef SORT_PRU_CLR_EN
            want = 0;
`else
            want = ref_cnt[0][k];
`endif
            n_vec++;
            if (int'(mem[0][k]) !== want) begin
                n_err++;
                $display("FAIL clear_bank0[%0d] got %0d required %0d", k, mem[0][k], want);
            end
            n_vec++;
            if (int'(mem[1][k]) !== ref_cnt[1][k]) begin
                n_err++;
                $display("FAIL clear_bank1[%0d] got %0d required %0d", k, mem[1][k],
                         ref_cnt[1][k]);
            end
        end
    endtask

    task automatic test_empty_bank();
        int lat, d0;
        bit ok;
        load_bank(0, 3, 3, 3, 3);
        load_bank(1, 0, 0, 0, 0);
        rdy_mode = 0;
        sel_err = 0;
        d0 = done_cnt;
        run_op(1'b1, 100, lat, ok);
        n_vec++;
        if (!ok || done_cnt !== d0 + 1) begin
            n_err++;
            $display("FAIL empty_done got %0d pulses required 1", done_cnt - d0);
        end
        n_vec++;
        if (got_q.size() !== 0) begin
            n_err++;
            $display("FAIL empty_xfers got %0d required 0", got_q.size());
        end
        n_vec++;
        if (lat !== 3 * N + 1) begin
            n_err++;
            $display("FAIL empty_latency got %0d required %0d", lat, 3 * N + 1);
        end
        n_vec++;
        if (sel_err !== 0) begin
            n_err++;
            $display("FAIL empty_sel got %0d wrong-bank strobes required 0", sel_err);
        end
    endtask

    task automatic test_stall();
        int lat, d0;
        bit ok;
        load_bank(0, 0, 5, 0, 0);
        rdy_mode = 1;
        stall_err = 0;
        d0 = done_cnt;
        run_op(1'b0, 300, lat, ok);
        n_vec++;
        if (!ok || done_cnt !== d0 + 1) begin
            n_err++;
            $display("FAIL stall_done got %0d pulses required 1", done_cnt - d0);
        end
        n_vec++;
        if (got_q.size() !== 5) begin
            n_err++;
            $display("FAIL stall_len got %0d required 5", got_q.size());
        end
        for (int i = 0; i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== 2'd1) begin
                n_err++;
                $display("FAIL stall_key[%0d] got %0d required 1", i, got_q[i]);
            end
        end
        n_vec++;
        if (stall_err !== 0) begin
            n_err++;
            $display("FAIL stall_hold got %0d unstable cycles required 0", stall_err);
        end
    endtask

    task automatic test_restart_ignored();
        int sum, d0;
        load_bank(0, 2, 0, 1, 3);
        load_bank(1, 1, 1, 1, 1);
        build_exp(0, sum);
        rdy_mode = 1;
        sel_err = 0;
        exp_sel = 1'b0;
        got_q.delete();
        d0 = done_cnt;
        @(posedge clk);
        #1;
        start = 1'b1;
        sel_i = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 50 && !out_vld; i++) @(posedge clk);
        #2;
        start = 1'b1;
        sel_i = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        sel_i = 1'b0;
        for (int i = 0; i < 200 && done_cnt == d0; i++) @(posedge clk);
        repeat (40) @(posedge clk);
        n_vec++;
        if (done_cnt !== d0 + 1) begin
            n_err++;
            $display("FAIL restart_done got %0d pulses required 1", done_cnt - d0);
        end
        n_vec++;
        if (got_q.size() !== exp_q.size()) begin
            n_err++;
            $display("FAIL restart_len got %0d required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL restart_key[%0d] got %0d required %0d", i, got_q[i], exp_q[i]);
            end
        end
        n_vec++;
        if (sel_err !== 0) begin
            n_err++;
            $display("FAIL restart_sel got %0d wrong-bank strobes required 0", sel_err);
        end
    endtask

    task automatic test_reset_mid_emit();
        int lat, sum, d0;
        bit ok;
        load_bank(0, 1, 2, 0, 0);
        rdy_mode = 3;
        exp_sel = 1'b0;
        d0 = done_cnt;
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 50 && !out_vld; i++) @(posedge clk);
        n_vec++;
        if (out_vld !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_emit got vld=%b required 1", out_vld);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({done, rd_en, sel_o, addr, clr_en, out_vld, out_data} !== '0) begin
            n_err++;
            $display("FAIL midrst_outputs got %b required 0",
                     {done, rd_en, sel_o, addr, clr_en, out_vld, out_data});
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3 * N + 4) @(posedge clk);
        n_vec++;
        if (done_cnt !== d0) begin
            n_err++;
            $display("FAIL midrst_no_done got %0d pulses required 0", done_cnt - d0);
        end
        load_bank(0, 1, 2, 0, 0);
        build_exp(0, sum);
        rdy_mode = 0;
        run_op(1'b0, 200, lat, ok);
        n_vec++;
        if (!ok || got_q.size() !== exp_q.size()) begin
            n_err++;
            $display("FAIL midrst_restart_len got %0d required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL midrst_key[%0d] got %0d required %0d", i, got_q[i], exp_q[i]);
            end
        end
        n_vec++;
        if (lat !== 3 * N + 1 + sum) begin
            n_err++;
            $display("FAIL midrst_latency got %0d required %0d", lat, 3 * N + 1 + sum);
        end
    endtask

    task automatic test_random();
        int lat, sum, d0;
        bit ok;
        logic s;
        for (int it = 0; it < 20; it++) begin
            for (int b = 0; b < 2; b++) begin
                load_bank(b, $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 3), $urandom_range(0, 3));
            end
            s = 1'($urandom_range(0, 1));
            build_exp(int'(s), sum);
            rdy_mode = (it % 2 == 0) ? 0 : 2;
            stall_err = 0;
            sel_err = 0;
            d0 = done_cnt;
            run_op(s, 400, lat, ok);
            n_vec++;
            if (!ok || done_cnt !== d0 + 1) begin
                n_err++;
                $display("FAIL rand%0d_done got %0d pulses required 1", it, done_cnt - d0);
            end
            n_vec++;
            if (got_q.size() !== exp_q.size()) begin
                n_err++;
                $display("FAIL rand%0d_len got %0d required %0d", it, got_q.size(),
                         exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                n_vec++;
                if (got_q[i] !== exp_q[i]) begin
                    n_err++;
                    $display("FAIL rand%0d_key[%0d] got %0d required %0d", it, i, got_q[i],
                             exp_q[i]);
                end
            end
            if (rdy_mode == 0) begin
                n_vec++;
                if (lat !== 3 * N + 1 + sum) begin
                    n_err++;
                    $display("FAIL rand%0d_latency got %0d required %0d", it, lat,
                             3 * N + 1 + sum);
                end
            end
            n_vec++;
            if (stall_err !== 0 || sel_err !== 0) begin
                n_err++;
                $display("FAIL rand%0d_proto got stall=%0d sel=%0d required 0/0", it,
                         stall_err, sel_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sort_basic();
        test_clear();
        test_empty_bank();
        test_stall();
        test_restart_ignored();
        test_reset_mid_emit();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
